// File: rtl/fifo_write_arbiter.sv
// Two-producer round-robin write arbiter in front of a FIFO write port.
// Bursts are capped at MAX_BURST words while the other producer waits; writes pass through with zero latency.
module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] din1,
  output logic                  gnt1,
  input  logic                  req2,
  input  logic [DATA_WIDTH-1:0] din2,
  output logic                  gnt2,
  input  logic                  full,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] din,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2
  } state_t;

  typedef enum logic {
    OWNER1 = 1'b0,
    OWNER2 = 1'b1
  } owner_t;

  state_t          state, state_nxt;
  owner_t          last_owner, last_owner_nxt;
  logic [BW-1:0]   burst_cnt, burst_cnt_nxt;
  logic            accept1, accept2;

  function automatic logic burst_done(input logic [BW-1:0] cnt);
    return cnt == BW'(MAX_BURST - 1);
  endfunction

  // Grants come straight off the state register, so async reset drops them at once.
  assign gnt1    = (state == OWN1);
  assign gnt2    = (state == OWN2);
  assign accept1 = gnt1 & req1 & ~full;
  assign accept2 = gnt2 & req2 & ~full;
  assign wr_en   = accept1 | accept2;

  always_comb begin
    din = '0;
    if (gnt1)
      din = din1;
    else if (gnt2)
      din = din2;
  end

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    unique case (state)
      IDLE: begin
        if (req1 && req2)
          state_nxt = (last_owner == OWNER1) ? OWN2 : OWN1;
        else if (req1)
          state_nxt = OWN1;
        else if (req2)
          state_nxt = OWN2;
      end
      // A full FIFO freezes the whole owner context; nothing moves until it drains.
      OWN1: begin
        if (!full) begin
          if (!req1) begin
            state_nxt      = req2 ? OWN2 : IDLE;
            last_owner_nxt = OWNER1;
            burst_cnt_nxt  = '0;
          end else if (burst_done(burst_cnt)) begin
            burst_cnt_nxt = '0;
            if (req2) begin
              state_nxt      = OWN2;
              last_owner_nxt = OWNER1;
            end
          end else begin
            burst_cnt_nxt = burst_cnt + BW'(1);
          end
        end
      end
      OWN2: begin
        if (!full) begin
          if (!req2) begin
            state_nxt      = req1 ? OWN1 : IDLE;
            last_owner_nxt = OWNER2;
            burst_cnt_nxt  = '0;
          end else if (burst_done(burst_cnt)) begin
            burst_cnt_nxt = '0;
            if (req1) begin
              state_nxt      = OWN1;
              last_owner_nxt = OWNER2;
            end
          end else begin
            burst_cnt_nxt = burst_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWNER2;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      word_count <= '0;
    else if (wr_en)
      word_count <= word_count + CNT_WIDTH'(1);
  end

endmodule
